// File: rtl/cache_sram_arbiter_if.sv
// Requester and SRAM-side signals of cache_sram_arbiter.
// slave is the arbiter's view; master is the requesters plus the SRAM macro, which drives sram_rdata_i.
interface cache_sram_arbiter_if #(
  parameter int NumReq    = 2,
  parameter int AddrWidth = 10,
  parameter int DataWidth = 128,
  parameter int BeWidth   = 16
);
  logic [NumReq-1:0]           req_valid_i;
  logic [NumReq-1:0]           req_ready_o;
  logic [NumReq-1:0]           req_we_i;
  logic [NumReq*AddrWidth-1:0] req_addr_i;
  logic [NumReq*DataWidth-1:0] req_wdata_i;
  logic [NumReq*BeWidth-1:0]   req_be_i;
  logic [NumReq-1:0]           rsp_valid_o;
  logic [DataWidth-1:0]        rsp_rdata_o;
  logic                        sram_req_o;
  logic                        sram_we_o;
  logic [AddrWidth-1:0]        sram_addr_o;
  logic [DataWidth-1:0]        sram_wdata_o;
  logic [BeWidth-1:0]          sram_be_o;
  logic [DataWidth-1:0]        sram_rdata_i;

  modport master (
    output req_valid_i, req_we_i, req_addr_i, req_wdata_i, req_be_i, sram_rdata_i,
    input  req_ready_o, rsp_valid_o, rsp_rdata_o,
    input  sram_req_o, sram_we_o, sram_addr_o, sram_wdata_o, sram_be_o
  );

  modport slave (
    input  req_valid_i, req_we_i, req_addr_i, req_wdata_i, req_be_i, sram_rdata_i,
    output req_ready_o, rsp_valid_o, rsp_rdata_o,
    output sram_req_o, sram_we_o, sram_addr_o, sram_wdata_o, sram_be_o
  );
endinterface

// File: rtl/cache_sram_arbiter.sv
// Round-robin arbiter sharing one SRAM port among NumReq requesters, routing read data back by id.
// Define CACHE_SRAM_INIT_SWEEP_EN to zero every SRAM word after reset before any grant.
module cache_sram_arbiter #(
  parameter int NumReq    = 2,
  parameter int NumWords  = 1024,
  parameter int DataWidth = 128,
  parameter int ByteWidth = 8,
  parameter int Latency   = 1,
  parameter int AddrWidth = (NumWords > 1) ? $clog2(NumWords) : 1,
  parameter int BeWidth   = (DataWidth + ByteWidth - 1) / ByteWidth
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  cache_sram_arbiter_if.slave  bus,
  output logic                 init_done_o
);

  localparam int IdWidth = (NumReq > 1) ? $clog2(NumReq) : 1;

`ifdef CACHE_SRAM_INIT_SWEEP_EN
  typedef enum logic [0:0] {ST_INIT = 1'b0, ST_RUN = 1'b1} state_e;
  localparam state_e RstState = ST_INIT;
`else
  typedef enum logic [0:0] {ST_RUN = 1'b1} state_e;
  localparam state_e RstState = ST_RUN;
`endif

  state_e                          state_q, state_d;
  logic [IdWidth-1:0]              ptr_q, ptr_d;
  logic [Latency-1:0]              pipe_vld_q, pipe_vld_d;
  logic [Latency-1:0][IdWidth-1:0] pipe_id_q, pipe_id_d;
`ifdef CACHE_SRAM_INIT_SWEEP_EN
  logic [AddrWidth-1:0]            cnt_q, cnt_d;
`endif

  logic                 run_s;
  logic                 any_vld_s;
  logic                 hi_vld_s;
  logic [IdWidth-1:0]   hi_id_s;
  logic [IdWidth-1:0]   lo_id_s;
  logic [IdWidth-1:0]   gnt_id_s;
  logic                 grant_s;
  logic                 sel_we_s;
  logic [AddrWidth-1:0] sel_addr_s;
  logic [DataWidth-1:0] sel_wdata_s;
  logic [BeWidth-1:0]   sel_be_s;

  // Round-robin pick: lowest valid index at or above ptr, else lowest valid overall (wrap).
  always_comb begin
    run_s     = (state_q == ST_RUN) && !rst_i;
    any_vld_s = 1'b0;
    hi_vld_s  = 1'b0;
    hi_id_s   = '0;
    lo_id_s   = '0;
    for (int i = NumReq - 1; i >= 0; i--) begin
      any_vld_s = any_vld_s | bus.req_valid_i[i];
      lo_id_s   = bus.req_valid_i[i] ? IdWidth'(i) : lo_id_s;
      hi_vld_s  = (bus.req_valid_i[i] && (IdWidth'(i) >= ptr_q)) ? 1'b1 : hi_vld_s;
      hi_id_s   = (bus.req_valid_i[i] && (IdWidth'(i) >= ptr_q)) ? IdWidth'(i) : hi_id_s;
    end
    gnt_id_s = hi_vld_s ? hi_id_s : lo_id_s;
    grant_s  = run_s && any_vld_s;
  end

  // Select the winner's request fields.
  always_comb begin
    sel_we_s    = 1'b0;
    sel_addr_s  = '0;
    sel_wdata_s = '0;
    sel_be_s    = '0;
    for (int i = 0; i < NumReq; i++) begin
      if (gnt_id_s == IdWidth'(i)) begin
        sel_we_s    = bus.req_we_i[i];
        sel_addr_s  = bus.req_addr_i[i*AddrWidth +: AddrWidth];
        sel_wdata_s = bus.req_wdata_i[i*DataWidth +: DataWidth];
        sel_be_s    = bus.req_be_i[i*BeWidth +: BeWidth];
      end else begin
        sel_we_s    = sel_we_s;
      end
    end
  end

  // Drive ready and the SRAM port; everything is held low while reset is asserted.
  always_comb begin
    for (int i = 0; i < NumReq; i++) begin
      bus.req_ready_o[i] = grant_s && (gnt_id_s == IdWidth'(i));
    end
    bus.sram_req_o   = 1'b0;
    bus.sram_we_o    = 1'b0;
    bus.sram_addr_o  = '0;
    bus.sram_wdata_o = '0;
    bus.sram_be_o    = '0;
`ifdef CACHE_SRAM_INIT_SWEEP_EN
    if (!rst_i && (state_q == ST_INIT)) begin
      bus.sram_req_o   = 1'b1;
      bus.sram_we_o    = 1'b1;
      bus.sram_addr_o  = cnt_q;
      bus.sram_wdata_o = '0;
      bus.sram_be_o    = '1;
    end else
`endif
    if (grant_s) begin
      bus.sram_req_o   = 1'b1;
      bus.sram_we_o    = sel_we_s;
      bus.sram_addr_o  = sel_addr_s;
      bus.sram_wdata_o = sel_wdata_s;
      bus.sram_be_o    = sel_be_s;
    end else begin
      bus.sram_req_o   = 1'b0;
    end
  end

  // Route the last pipeline stage to its requester; read data passes straight through.
  always_comb begin
    for (int i = 0; i < NumReq; i++) begin
      bus.rsp_valid_o[i] = pipe_vld_q[Latency-1] && !rst_i &&
                           (pipe_id_q[Latency-1] == IdWidth'(i));
    end
    bus.rsp_rdata_o = bus.sram_rdata_i;
    init_done_o     = (state_q == ST_RUN) && !rst_i;
  end

  // Next-state: pointer advance, response pipeline shift, sweep counter.
  always_comb begin
    if (grant_s) begin
      ptr_d = (gnt_id_s == IdWidth'(NumReq - 1)) ? '0 : gnt_id_s + IdWidth'(1);
    end else begin
      ptr_d = ptr_q;
    end
    pipe_vld_d    = '0;
    pipe_id_d     = '0;
    pipe_vld_d[0] = grant_s && !sel_we_s;
    pipe_id_d[0]  = gnt_id_s;
    for (int s = 1; s < Latency; s++) begin
      pipe_vld_d[s] = pipe_vld_q[s-1];
      pipe_id_d[s]  = pipe_id_q[s-1];
    end
    state_d = state_q;
`ifdef CACHE_SRAM_INIT_SWEEP_EN
    cnt_d = cnt_q;
    case (state_q)
      ST_INIT: begin
        if (cnt_q == AddrWidth'(NumWords - 1)) begin
          state_d = ST_RUN;
          cnt_d   = '0;
        end else begin
          cnt_d   = cnt_q + AddrWidth'(1);
        end
      end
      ST_RUN:  state_d = ST_RUN;
      default: state_d = ST_INIT;
    endcase
`endif
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= RstState;
      ptr_q      <= '0;
      pipe_vld_q <= '0;
      pipe_id_q  <= '0;
`ifdef CACHE_SRAM_INIT_SWEEP_EN
      cnt_q      <= '0;
`endif
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      pipe_vld_q <= pipe_vld_d;
      pipe_id_q  <= pipe_id_d;
`ifdef CACHE_SRAM_INIT_SWEEP_EN
      cnt_q      <= cnt_d;
`endif
    end
  end

endmodule

// File: tb/tb_cache_sram_arbiter.sv
// Directed bench for cache_sram_arbiter: a Latency=1 instance driven from a vector table and a
// Latency=3 instance for latency, alternation and reset-flush sequences.
module tb_cache_sram_arbiter;
  localparam int NW = 1024;
  localparam int DW = 32;
  localparam int AW = 10;
  localparam int BW = 4;

  logic clk;
  logic rst_a;
  logic rst_b;
  logic done_a;
  logic done_b;
  int   total;
  int   bad;

  cache_sram_arbiter_if #(.NumReq(2), .AddrWidth(AW), .DataWidth(DW), .BeWidth(BW)) bus_a ();
  cache_sram_arbiter_if #(.NumReq(2), .AddrWidth(AW), .DataWidth(DW), .BeWidth(BW)) bus_b ();

  cache_sram_arbiter #(.NumReq(2), .NumWords(NW), .DataWidth(DW), .ByteWidth(8), .Latency(1)) dut_a (
    .clk_i(clk), .rst_i(rst_a), .bus(bus_a), .init_done_o(done_a)
  );
  cache_sram_arbiter #(.NumReq(2), .NumWords(NW), .DataWidth(DW), .ByteWidth(8), .Latency(3)) dut_b (
    .clk_i(clk), .rst_i(rst_b), .bus(bus_b), .init_done_o(done_b)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // SRAM model, latency 1
  logic [DW-1:0] mem_a [0:NW-1];
  logic [DW-1:0] rd_a;
  always @(posedge clk) begin
    if (bus_a.sram_req_o && bus_a.sram_we_o) begin
      for (int b = 0; b < BW; b++)
        if (bus_a.sram_be_o[b]) mem_a[bus_a.sram_addr_o][b*8 +: 8] <= bus_a.sram_wdata_o[b*8 +: 8];
    end else if (bus_a.sram_req_o) begin
      rd_a <= mem_a[bus_a.sram_addr_o];
    end
  end
  assign bus_a.sram_rdata_i = rd_a;

  // SRAM model, latency 3
  logic [DW-1:0] mem_b [0:NW-1];
  logic [DW-1:0] rd_b0, rd_b1, rd_b2;
  always @(posedge clk) begin
    if (bus_b.sram_req_o && bus_b.sram_we_o) begin
      for (int b = 0; b < BW; b++)
        if (bus_b.sram_be_o[b]) mem_b[bus_b.sram_addr_o][b*8 +: 8] <= bus_b.sram_wdata_o[b*8 +: 8];
    end else if (bus_b.sram_req_o) begin
      rd_b0 <= mem_b[bus_b.sram_addr_o];
    end
    rd_b1 <= rd_b0;
    rd_b2 <= rd_b1;
  end
  assign bus_b.sram_rdata_i = rd_b2;

  typedef struct packed {
    logic [1:0]    valid;
    logic          we;
    logic [AW-1:0] a0;
    logic [AW-1:0] a1;
    logic [DW-1:0] wd;
    logic [BW-1:0] be;
    logic [1:0]    er;
    logic [1:0]    ersp;
    logic          chk;
    logic [DW-1:0] ed;
  } vec_t;

  vec_t vecs [0:19];

  function automatic vec_t mkv(input logic [1:0] v, input logic w, input logic [AW-1:0] a0,
                               input logic [AW-1:0] a1, input logic [DW-1:0] wd, input logic [BW-1:0] be,
                               input logic [1:0] er, input logic [1:0] ersp, input logic chk,
                               input logic [DW-1:0] ed);
    vec_t r;
    r.valid = v; r.we = w; r.a0 = a0; r.a1 = a1; r.wd = wd; r.be = be;
    r.er = er; r.ersp = ersp; r.chk = chk; r.ed = ed;
    return r;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_a(input logic [1:0] v, input logic w, input logic [AW-1:0] a0,
                         input logic [AW-1:0] a1, input logic [DW-1:0] wd, input logic [BW-1:0] be);
    bus_a.req_valid_i = v;
    bus_a.req_we_i    = {w, w};
    bus_a.req_addr_i  = {a1, a0};
    bus_a.req_wdata_i = {wd, wd};
    bus_a.req_be_i    = {be, be};
  endtask

  task automatic drive_b(input logic [1:0] v);
    bus_b.req_valid_i = v;
    bus_b.req_we_i    = 2'b00;
    bus_b.req_addr_i  = {10'd3, 10'd2};
    bus_b.req_wdata_i = '0;
    bus_b.req_be_i    = '0;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  logic [1:0]    er2, ersp2;
  logic [AW-1:0] exp_addr;
  int            j;
  int            exp_j;

  initial begin
    total = 0;
    bad   = 0;
    vecs[0]  = mkv(2'b11, 1'b0, 10'd1, 10'd2, 32'h0, 4'h0, 2'b01, 2'b00, 1'b0, 32'h0);
    vecs[1]  = mkv(2'b11, 1'b0, 10'd1, 10'd2, 32'h0, 4'h0, 2'b10, 2'b01, 1'b0, 32'h0);
    vecs[2]  = mkv(2'b11, 1'b0, 10'd3, 10'd4, 32'h0, 4'h0, 2'b01, 2'b10, 1'b0, 32'h0);
    vecs[3]  = mkv(2'b10, 1'b1, 10'd9, 10'd5, 32'hA5A5A5A5, 4'hF, 2'b10, 2'b01, 1'b0, 32'h0);
    vecs[4]  = mkv(2'b01, 1'b0, 10'd5, 10'd7, 32'h0, 4'h0, 2'b01, 2'b00, 1'b0, 32'h0);
    vecs[5]  = mkv(2'b00, 1'b0, 10'd0, 10'd0, 32'h0, 4'h0, 2'b00, 2'b01, 1'b1, 32'hA5A5A5A5);
    vecs[6]  = mkv(2'b11, 1'b0, 10'd6, 10'd7, 32'h0, 4'h0, 2'b10, 2'b00, 1'b0, 32'h0);
    for (int k = 7; k < 15; k++)
      vecs[k] = mkv(2'b10, 1'b0, 10'd0, 10'd8, 32'h0, 4'h0, 2'b10, 2'b10, 1'b0, 32'h0);
    vecs[15] = mkv(2'b11, 1'b0, 10'd5, 10'd8, 32'h0, 4'h0, 2'b01, 2'b10, 1'b0, 32'h0);
    vecs[16] = mkv(2'b00, 1'b0, 10'd0, 10'd0, 32'h0, 4'h0, 2'b00, 2'b01, 1'b1, 32'hA5A5A5A5);
    vecs[17] = mkv(2'b01, 1'b1, 10'd5, 10'd0, 32'h11223344, 4'h3, 2'b01, 2'b00, 1'b0, 32'h0);
    vecs[18] = mkv(2'b01, 1'b0, 10'd5, 10'd0, 32'h0, 4'h0, 2'b01, 2'b00, 1'b0, 32'h0);
    vecs[19] = mkv(2'b00, 1'b0, 10'd0, 10'd0, 32'h0, 4'h0, 2'b00, 2'b01, 1'b1, 32'hA5A53344);

    // Reset: outputs must stay low even with requests pending.
    rst_a = 1'b1;
    rst_b = 1'b1;
    drive_a(2'b11, 1'b1, 10'd7, 10'd9, 32'hDEADBEEF, 4'hF);
    drive_b(2'b11);
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_a", {11'd0, bus_a.req_ready_o, bus_a.rsp_valid_o, bus_a.sram_req_o, bus_a.sram_we_o,
                      bus_a.sram_addr_o, bus_a.sram_wdata_o, bus_a.sram_be_o, done_a}, 64'd0);
    check("reset_b", {11'd0, bus_b.req_ready_o, bus_b.rsp_valid_o, bus_b.sram_req_o, bus_b.sram_we_o,
                      bus_b.sram_addr_o, bus_b.sram_wdata_o, bus_b.sram_be_o, done_b}, 64'd0);
    next_cycle();
    rst_a = 1'b0;
    rst_b = 1'b0;
    drive_b(2'b00);
    drive_a(2'b11, 1'b0, 10'd7, 10'd9, 32'h0, 4'h0);

`ifdef CACHE_SRAM_INIT_SWEEP_EN
    for (int k = 0; k < NW; k++) begin
      @(negedge clk);
      check("sweep", {20'd0, bus_a.req_ready_o, done_a, bus_a.sram_req_o, bus_a.sram_we_o,
                      bus_a.sram_addr_o, bus_a.sram_wdata_o, bus_a.sram_be_o},
                     {20'd0, 2'b00, 1'b0, 1'b1, 1'b1, AW'(k), 32'h0, 4'hF});
      next_cycle();
      if (k == NW - 1) drive_a(2'b00, 1'b0, 10'd0, 10'd0, 32'h0, 4'h0);
    end
    @(negedge clk);
    check("init_done_a", {63'd0, done_a}, 64'd1);
`else
    drive_a(2'b00, 1'b0, 10'd0, 10'd0, 32'h0, 4'h0);
    @(negedge clk);
    check("init_done_a", {63'd0, done_a}, 64'd1);
    check("init_done_b", {63'd0, done_b}, 64'd1);
`endif
    next_cycle();

    // Table on the Latency=1 instance.
    for (int k = 0; k < 20; k++) begin
      drive_a(vecs[k].valid, vecs[k].we, vecs[k].a0, vecs[k].a1, vecs[k].wd, vecs[k].be);
      @(negedge clk);
      check($sformatf("ready[%0d]", k), {62'd0, bus_a.req_ready_o}, {62'd0, vecs[k].er});
      check($sformatf("rsp[%0d]", k), {62'd0, bus_a.rsp_valid_o}, {62'd0, vecs[k].ersp});
      if (vecs[k].chk) check($sformatf("rdata[%0d]", k), {32'd0, bus_a.rsp_rdata_o}, {32'd0, vecs[k].ed});
      if (vecs[k].er != 2'b00) begin
        exp_addr = vecs[k].er[1] ? vecs[k].a1 : vecs[k].a0;
        check($sformatf("sram_cmd[%0d]", k), {52'd0, bus_a.sram_req_o, bus_a.sram_we_o, bus_a.sram_addr_o},
                                             {52'd0, 1'b1, vecs[k].we, exp_addr});
        if (vecs[k].we)
          check($sformatf("sram_wr[%0d]", k), {28'd0, bus_a.sram_wdata_o, bus_a.sram_be_o},
                                              {28'd0, vecs[k].wd, vecs[k].be});
      end else begin
        check($sformatf("sram_idle[%0d]", k), {63'd0, bus_a.sram_req_o}, 64'd0);
      end
      next_cycle();
    end

    // Latency=3: both requesters read every cycle for 6 cycles.
    for (int c = 0; c < 10; c++) begin
      drive_b((c < 6) ? 2'b11 : 2'b00);
      er2   = (c < 6) ? (((c % 2) == 0) ? 2'b01 : 2'b10) : 2'b00;
      ersp2 = (c >= 3 && c < 9) ? ((((c - 3) % 2) == 0) ? 2'b01 : 2'b10) : 2'b00;
      @(negedge clk);
      check($sformatf("l3_ready[%0d]", c), {62'd0, bus_b.req_ready_o}, {62'd0, er2});
      check($sformatf("l3_rsp[%0d]", c), {62'd0, bus_b.rsp_valid_o}, {62'd0, ersp2});
      next_cycle();
    end

    // Three reads from requester 0, then reset while they are in flight.
    for (int c = 0; c < 3; c++) begin
      drive_b(2'b01);
      @(negedge clk);
      check($sformatf("pre_rst_ready[%0d]", c), {62'd0, bus_b.req_ready_o}, 64'd1);
      next_cycle();
    end
    drive_b(2'b00);
    rst_b = 1'b1;
    @(negedge clk);
    check("rst_cycle_rsp", {62'd0, bus_b.rsp_valid_o}, 64'd0);
    next_cycle();
    rst_b = 1'b0;
    drive_b(2'b11);
    j = 0;
    while (1) begin
      @(negedge clk);
      if (j < 3) check($sformatf("flush_rsp[%0d]", j), {62'd0, bus_b.rsp_valid_o}, 64'd0);
`ifdef CACHE_SRAM_INIT_SWEEP_EN
      if (j == 0) check("sweep_restart", {52'd0, bus_b.sram_req_o, bus_b.sram_we_o, bus_b.sram_addr_o},
                                         {52'd0, 1'b1, 1'b1, 10'd0});
`endif
      if (done_b || j >= 2000) break;
      next_cycle();
      j++;
    end
`ifdef CACHE_SRAM_INIT_SWEEP_EN
    exp_j = NW;
`else
    exp_j = 0;
`endif
    check("init_cycles", 64'(j), 64'(exp_j));
    check("ptr_after_rst", {62'd0, bus_b.req_ready_o}, 64'd1);
    next_cycle();
    drive_b(2'b00);
    @(negedge clk);
    check("post_rst_rsp1", {62'd0, bus_b.rsp_valid_o}, 64'd0);
    next_cycle();
    @(negedge clk);
    check("post_rst_rsp2", {62'd0, bus_b.rsp_valid_o}, 64'd0);
    next_cycle();
    @(negedge clk);
    check("post_rst_rsp3", {62'd0, bus_b.rsp_valid_o}, 64'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
